// File: rtl/bsmodmul_pkg.sv
// Shared constants and helpers for the bit-serial modular multiplier.
package bsmodmul_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Modulus p = 2^len - c, returned wide; callers narrow it to len+1 bits.
  function automatic logic [63:0] modp_const(input int len, input int c);
    return (64'd1 << len) - 64'(c);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bsmodmul_gen_modaddsub.sv
// (x + y) mod p for x + y < 2p: one add followed by one conditional subtract.
module modaddsub
  import bsmodmul_pkg::*;
#(
  parameter int LEN = 22,
  parameter int C   = 3
) (
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  output logic [LEN-1:0] s
);

  localparam logic [LEN:0] P = (LEN+1)'(modp_const(LEN, C));

  logic [LEN:0]   sum;
  logic [LEN-1:0] diff;

  // The wrapped LEN-bit difference is exact whenever sum >= p, since sum - p < p.
  always_comb begin
    sum  = {1'b0, x} + {1'b0, y};
    diff = sum[LEN-1:0] - P[LEN-1:0];
    s    = (sum >= P) ? diff : sum[LEN-1:0];
  end

endmodule

// File: rtl/bsmodmul_gen.sv
// Bit-serial modular multiplier q = (a*b) mod (2^LEN - C); a and q serial LSB-first,
// b parallel, fixed latency LEN with back-to-back frames, stall and mid-frame restart.
module bsmodmul_gen
  import bsmodmul_pkg::*;
#(
  parameter int LEN = 22,
  parameter int C   = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ien,
  input  logic           a,
  input  logic [LEN-1:0] b,
  input  logic           isync,
  output logic           q,
  output logic           osync,
  output logic           busy
);

  localparam int             CW       = clog2(LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LEN - 1);

  state_t         state_q, state_d;
  logic [LEN-1:0] acc_q, acc_d;
  logic [LEN-1:0] pw_q, pw_d;
  logic [LEN-1:0] sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           osync_q, osync_d;

  logic [LEN-1:0] bmod, src, dbl, acc_in, addend, acc_sum;
  logic           last_bit;

  modaddsub #(.LEN(LEN), .C(C)) u_bmod (.x(b),      .y('0),     .s(bmod));
  modaddsub #(.LEN(LEN), .C(C)) u_dbl  (.x(src),    .y(src),    .s(dbl));
  modaddsub #(.LEN(LEN), .C(C)) u_acc  (.x(acc_in), .y(addend), .s(acc_sum));

  // On isync the weight is b itself and the accumulator starts empty.
  always_comb begin
    src      = isync ? bmod : pw_q;
    acc_in   = isync ? '0 : acc_q;
    addend   = a ? src : '0;
    last_bit = !isync && (state_q == ST_ACC) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (ien) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (isync) begin
      state_d = ST_ACC;
    end else if (last_bit) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    busy = (state_q == ST_ACC);
  end

  always_comb begin
    acc_d   = acc_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    sreg_d  = {1'b0, sreg_q[LEN-1:1]};
    osync_d = 1'b0;
    if (isync) begin
      acc_d = acc_sum;
      pw_d  = dbl;
      cnt_d = CW'(1);
    end else if (state_q == ST_ACC) begin
      acc_d = acc_sum;
      pw_d  = dbl;
      if (last_bit) begin
        cnt_d   = '0;
        sreg_d  = acc_sum;
        osync_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      pw_q    <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      osync_q <= 1'b0;
    end else if (ien) begin
      acc_q   <= acc_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      osync_q <= osync_d;
    end
  end

  always_comb begin
    q     = sreg_q[0];
    osync = osync_q;
  end

endmodule

// File: tb/tb_bsmodmul_gen.sv
// Bench for bsmodmul_gen: a (22,3) and an (8,5) instance checked every cycle against
// an arithmetic model of the output stream, plus hand-computed result literals.
module tb_bsmodmul_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_s[2];
  logic        isync_s[2];
  logic        ien_s[2];
  logic [21:0] b0 = '0;
  logic [7:0]  b1 = '0;
  logic        dq[2];
  logic        dos[2];
  logic        dbusy[2];

  int          n_checks = 0;
  int          n_fail = 0;
  int          ec[2];
  int          last_ec[2];
  int          col_idx[2];
  longint      col_val[2];
  longint      got0[$];
  longint      got1[$];
  bit [2:0]    tab[int];   // expected {busy, osync, q} keyed by instance and enabled-edge count

  always #5 clk = ~clk;

  bsmodmul_gen #(.LEN(22), .C(3)) dut0 (
    .clk(clk), .reset(reset), .ien(ien_s[0]), .a(a_s[0]), .b(b0),
    .isync(isync_s[0]), .q(dq[0]), .osync(dos[0]), .busy(dbusy[0])
  );

  bsmodmul_gen #(.LEN(8), .C(5)) dut1 (
    .clk(clk), .reset(reset), .ien(ien_s[1]), .a(a_s[1]), .b(b1),
    .isync(isync_s[1]), .q(dq[1]), .osync(dos[1]), .busy(dbusy[1])
  );

  function automatic int lenk(input int k);
    return (k == 0) ? 22 : 8;
  endfunction

  function automatic longint pk(input int k);
    return (k == 0) ? 64'd4194301 : 64'd251;
  endfunction

  function automatic int key(input int k, input int e);
    return k * (1 << 24) + e;
  endfunction

  function automatic void mark(input int k, input int e, input bit [2:0] v);
    int kk;
    kk = key(k, e);
    if (tab.exists(kk)) tab[kk] = tab[kk] | v;
    else tab[kk] = v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset && ien_s[k]) ec[k] <= ec[k] + 1;
    end
  end

  // Per-cycle compare against the model table, and deserialisation of each result.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit [2:0] e;
        int kk;
        kk = key(k, ec[k]);
        e = tab.exists(kk) ? tab[kk] : 3'b000;
        chk($sformatf("i%0d_q@%0d", k, ec[k]), 64'(dq[k]), 64'(e[0]));
        chk($sformatf("i%0d_osync@%0d", k, ec[k]), 64'(dos[k]), 64'(e[1]));
        chk($sformatf("i%0d_busy@%0d", k, ec[k]), 64'(dbusy[k]), 64'(e[2]));
        if (!reset) begin
          col_idx[k] = 0;
          col_val[k] = 0;
          last_ec[k] = ec[k];
        end else if (ec[k] != last_ec[k]) begin
          last_ec[k] = ec[k];
          if (dos[k]) begin
            col_val[k] = longint'(dq[k]);
            col_idx[k] = 1;
          end else if (col_idx[k] > 0) begin
            col_val[k] = col_val[k] | (longint'(dq[k]) << col_idx[k]);
            col_idx[k]++;
          end
          if (col_idx[k] == lenk(k)) begin
            if (k == 0) got0.push_back(col_val[k]);
            else got1.push_back(col_val[k]);
            col_idx[k] = 0;
          end
        end
      end
    end
  end

  task automatic drive(input int k, input bit av, input bit sv, input bit ev);
    @(posedge clk);
    #1;
    a_s[k] = av;
    isync_s[k] = sv;
    ien_s[k] = ev;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'($urandom_range(1)), 1'b0, 1'b1);
  endtask

  // Sends nbits of a frame; a full frame registers its output stream in the model.
  task automatic frame(input int k, input longint av, input longint bv,
                       input int nbits, input int stall_pct);
    int len;
    int e0;
    longint r;
    len = lenk(k);
    if (k == 0) b0 = 22'(bv);
    else b1 = 8'(bv);
    for (int i = 0; i < nbits; i++) begin
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(99) < stall_pct)
          drive(k, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      end
      drive(k, av[i], i == 0, 1'b1);
      if (i == 0) begin
        e0 = ec[k];
        if (nbits == len) begin
          r = (av * bv) % pk(k);
          for (int j = 0; j < len; j++) mark(k, e0 + len + j, {1'b0, j == 0, r[j]});
          for (int j = 1; j < len; j++) mark(k, e0 + j, 3'b100);
        end else begin
          for (int j = 1; j <= nbits; j++) mark(k, e0 + j, 3'b100);
        end
      end
    end
  endtask

  task automatic check_result(input int k, input longint exp, input string name);
    int n;
    longint v;
    n = 0;
    for (int t = 0; t < 200 && n == 0; t++) begin
      @(negedge clk);
      n = (k == 0) ? got0.size() : got1.size();
    end
    if (n == 0) begin
      chk({name, "_timeout"}, 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp));
    end else begin
      v = (k == 0) ? got0.pop_front() : got1.pop_front();
      $display("result %s: inst %0d q=%0d expected %0d", name, k, v, exp);
      chk(name, 64'(v), 64'(exp));
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    tab.delete();
    reset = 1'b0;
    #1;
    chk({name, "_q"}, 64'(dq[0]), 64'd0);
    chk({name, "_osync"}, 64'(dos[0]), 64'd0);
    chk({name, "_busy"}, 64'(dbusy[0]), 64'd0);
    for (int k = 0; k < 2; k++) begin
      a_s[k] = 1'b0;
      isync_s[k] = 1'b0;
      ien_s[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint amask;
    longint sweep_a[8];
    sweep_a = '{0, 1, 2, 127, 128, 250, 251, 255};
    amask = (64'd1 << 22) - 1;
    for (int k = 0; k < 2; k++) begin
      ec[k] = 0;
      last_ec[k] = -1;
      col_idx[k] = 0;
      col_val[k] = 0;
      a_s[k] = 1'b0;
      isync_s[k] = 1'b0;
      ien_s[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("reset_q", 64'(dq[0]), 64'd0);
    chk("reset_osync", 64'(dos[0]), 64'd0);
    chk("reset_busy", 64'(dbusy[0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(0, 3);

    frame(0, 2, 3, 22, 0);                 check_result(0, 6, "b3_a2");
    frame(0, 4194300, 4194300, 22, 0);     check_result(0, 1, "pm1_sq");
    frame(0, 1 << 21, 1 << 21, 22, 0);     check_result(0, 3145728, "pow21_sq");
    frame(0, 5, 4194302, 22, 0);           check_result(0, 5, "b_ge_p");
    idle(0, 30);

    for (int n = 0; n < 200; n++)
      frame(0, longint'($urandom) & amask, longint'($urandom) & amask, 22, 0);
    idle(0, 30);
    got0.delete();

    for (int n = 0; n < 30; n++)
      frame(0, longint'($urandom) & amask, longint'($urandom) & amask, 22, 30);
    idle(0, 30);
    got0.delete();
    frame(0, 2, 3, 22, 40);                check_result(0, 6, "stall_b3_a2");
    idle(0, 30);

    got0.delete();
    frame(0, 12345, 67890, 10, 0);
    frame(0, 1000, 3000, 22, 0);           check_result(0, 3000000, "abort_restart");
    idle(0, 30);
    chk("abort_extra_frames", 64'(got0.size()), 64'd0);

    frame(0, 123, 456, 8, 0);
    do_reset("rst_midframe");
    frame(0, 7, 9, 22, 0);                 check_result(0, 63, "after_reset");
    idle(0, 30);
    got0.delete();
    frame(0, 1, 64'h3FFFF0, 22, 0);
    idle(0, 8);
    do_reset("rst_midoutput");
    idle(0, 30);
    chk("truncated_frames", 64'(got0.size()), 64'd0);

    frame(1, 250, 250, 8, 0);              check_result(1, 1, "p8_250_sq");
    frame(1, 255, 255, 8, 0);              check_result(1, 16, "p8_255_sq");
    idle(1, 10);
    for (int i = 0; i < 8; i++)
      for (int bv = 0; bv < 256; bv++) frame(1, sweep_a[i], longint'(bv), 8, 0);
    for (int n = 0; n < 300; n++)
      frame(1, longint'($urandom_range(255)), longint'($urandom_range(255)), 8, 20);
    idle(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
